pipe_skid_fifo: RTL and testbench

Parametrised successor to the two-register pipeline skid buffer. It is a DEPTH-entry elastic buffer with valid/ready handshakes on both sides, a registered `o_ready`, and occupancy/almost-full status. It sits between pipeline stages that need more than one entry of slack, for example across long ready paths or bursty producers. Full throughput is one transfer per cycle in both directions.

---
 rtl/pipe_skid_fifo.sv | 125 ++++++++++++
 tb/tb_pipe_skid_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_fifo.sv
// Elastic valid/ready buffer of DEPTH entries with a registered o_ready and o_afull.
// Define PIPE_SKID_FIFO_FLUSH_EN to add the synchronous i_flush port.
module pipe_skid_fifo #(
  parameter int DWIDTH       = 8,
  parameter int DEPTH        = 2,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DWIDTH-1:0]          i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [DWIDTH-1:0]          o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_afull,
  output logic                       o_empty
`ifdef PIPE_SKID_FIFO_FLUSH_EN
  ,
  input  logic                       i_flush
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_COUNT = CW'(AFULL_THRESH);
  localparam logic [PW-1:0] LAST_PTR    = PW'(DEPTH - 1);

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_next_s;
  logic [PW-1:0]     rd_ptr_next_s;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic              ready_r;
  logic              afull_r;
  logic              valid_s;
  logic              run_s;
  logic              push_s;
  logic              pop_s;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == LAST_PTR) begin
      nxt = '0;
    end else begin
      nxt = ptr + PW'(1);
    end
    return nxt;
  endfunction

`ifdef PIPE_SKID_FIFO_FLUSH_EN
  assign run_s = ~i_flush;
`else
  assign run_s = 1'b1;
`endif

  assign valid_s = (count_r != '0);

  // Handshake qualification and next-state for pointers and occupancy.
  always_comb begin
    push_s        = i_valid & ready_r & run_s;
    pop_s         = valid_s & i_ready & run_s;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    if (!run_s) begin
      wr_ptr_next_s = '0;
      rd_ptr_next_s = '0;
      count_next_s  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_next_s = ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1);
        2'b01:   count_next_s = count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Control state; ready/afull are precomputed from the next occupancy so they leave a flop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ready_r  <= 1'b0;
      afull_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      ready_r  <= (count_next_s != FULL_COUNT);
      afull_r  <= (count_next_s >= AFULL_COUNT);
    end
  end

  // Storage array; contents need no reset because o_data is only meaningful with o_valid.
  always_ff @(posedge clk) begin
    if (rstn && push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  assign o_ready = ready_r;
  assign o_afull = afull_r;
  assign o_count = count_r;
  assign o_valid = valid_s;
  assign o_empty = ~valid_s;
  assign o_data  = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_pipe_skid_fifo.sv
// Self-checking bench for pipe_skid_fifo: three instances (DEPTH 4, 3, 2) share clock and reset.
module tb_pipe_skid_fifo;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH 4, AFULL_THRESH 3
  logic [7:0] a_idata, a_odata;
  logic       a_ivalid, a_oready, a_ovalid, a_iready, a_afull, a_empty;
  logic [2:0] a_count;
  // Instance B: DEPTH 3
  logic [7:0] b_idata, b_odata;
  logic       b_ivalid, b_oready, b_ovalid, b_iready, b_afull, b_empty;
  logic [1:0] b_count;
  // Instance C: DEPTH 2
  logic [7:0] c_idata, c_odata;
  logic       c_ivalid, c_oready, c_ovalid, c_iready, c_afull, c_empty;
  logic [1:0] c_count;
`ifdef PIPE_SKID_FIFO_FLUSH_EN
  logic a_flush = 1'b0;
  logic b_flush = 1'b0;
  logic c_flush = 1'b0;
`endif

  pipe_skid_fifo #(.DWIDTH(8), .DEPTH(4), .AFULL_THRESH(3)) u_a (
    .clk(clk), .rstn(rstn), .i_data(a_idata), .i_valid(a_ivalid), .o_ready(a_oready),
    .o_data(a_odata), .o_valid(a_ovalid), .i_ready(a_iready), .o_count(a_count),
    .o_afull(a_afull), .o_empty(a_empty)
`ifdef PIPE_SKID_FIFO_FLUSH_EN
    , .i_flush(a_flush)
`endif
  );

  pipe_skid_fifo #(.DWIDTH(8), .DEPTH(3), .AFULL_THRESH(2)) u_b (
    .clk(clk), .rstn(rstn), .i_data(b_idata), .i_valid(b_ivalid), .o_ready(b_oready),
    .o_data(b_odata), .o_valid(b_ovalid), .i_ready(b_iready), .o_count(b_count),
    .o_afull(b_afull), .o_empty(b_empty)
`ifdef PIPE_SKID_FIFO_FLUSH_EN
    , .i_flush(b_flush)
`endif
  );

  pipe_skid_fifo #(.DWIDTH(8), .DEPTH(2), .AFULL_THRESH(1)) u_c (
    .clk(clk), .rstn(rstn), .i_data(c_idata), .i_valid(c_ivalid), .o_ready(c_oready),
    .o_data(c_odata), .o_valid(c_ovalid), .i_ready(c_iready), .o_count(c_count),
    .o_afull(c_afull), .o_empty(c_empty)
`ifdef PIPE_SKID_FIFO_FLUSH_EN
    , .i_flush(c_flush)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_ivalid = 1'b0; a_iready = 1'b0; a_idata = 8'h00;
    b_ivalid = 1'b0; b_iready = 1'b0; b_idata = 8'h00;
    c_ivalid = 1'b0; c_iready = 1'b0; c_idata = 8'h00;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_ovalid !== 1'b0 || a_count !== 3'd0 || a_empty !== 1'b1 || a_oready !== 1'b0 || a_afull !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: valid=%b count=%0d empty=%b ready=%b afull=%b, required 0 0 1 0 0",
                 a_ovalid, a_count, a_empty, a_oready, a_afull);
      end
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (a_oready !== 1'b0 || b_oready !== 1'b0 || c_oready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_ready: got a=%b b=%b c=%b, required 0", a_oready, b_oready, c_oready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_oready !== 1'b1 || b_oready !== 1'b1 || c_oready !== 1'b1) begin
        errors++;
        $display("FAIL reset_later_ready: got a=%b b=%b c=%b, required 1", a_oready, b_oready, c_oready);
      end
      checks++;
      if (a_ovalid !== 1'b0 || a_count !== 3'd0 || a_empty !== 1'b1 || b_ovalid !== 1'b0 || c_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: a valid=%b count=%0d empty=%b b valid=%b c valid=%b, required 0 0 1 0 0",
                 a_ovalid, a_count, a_empty, b_ovalid, c_ovalid);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    a_iready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_ivalid = 1'b1;
      a_idata  = vals[i];
      tick();
      checks++;
      if (a_count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_count: got %0d, required %0d", a_count, i + 1);
      end
      checks++;
      if (a_afull !== ((i + 1) >= 3)) begin
        errors++;
        $display("FAIL fill_afull: got %b at count %0d, required %b", a_afull, i + 1, ((i + 1) >= 3));
      end
      checks++;
      if (a_oready !== ((i + 1) < 4)) begin
        errors++;
        $display("FAIL fill_ready: got %b at count %0d, required %b", a_oready, i + 1, ((i + 1) < 4));
      end
    end
    a_idata = 8'h55;
    tick();
    checks++;
    if (a_count !== 3'd4 || a_oready !== 1'b0 || a_odata !== 8'h11) begin
      errors++;
      $display("FAIL full_reject: count=%0d ready=%b data=%h, required 4 0 11", a_count, a_oready, a_odata);
    end
    a_ivalid = 1'b0;
    a_iready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_ovalid !== 1'b1 || a_odata !== vals[i]) begin
        errors++;
        $display("FAIL drain_data: valid=%b data=%h, required 1 %h", a_ovalid, a_odata, vals[i]);
      end
      tick();
    end
    checks++;
    if (a_ovalid !== 1'b0 || a_empty !== 1'b1 || a_count !== 3'd0) begin
      errors++;
      $display("FAIL drain_end: valid=%b empty=%b count=%0d, required 0 1 0", a_ovalid, a_empty, a_count);
    end
    a_iready = 1'b0;
  endtask

  task automatic test_streaming();
    int got = 0;
    a_iready = 1'b1;
    for (int k = 0; k < 101; k++) begin
      a_ivalid = (k < 100);
      a_idata  = 8'(k);
      if (k > 0) begin
        checks++;
        if (a_oready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready: got %b at cycle %0d, required 1", a_oready, k);
        end
        checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 8'(got)) begin
          errors++;
          $display("FAIL stream_data: valid=%b data=%h, required 1 %h", a_ovalid, a_odata, 8'(got));
        end
        got++;
      end
      tick();
      if (k < 100) begin
        checks++;
        if (a_count !== 3'd1) begin
          errors++;
          $display("FAIL stream_count: got %0d at cycle %0d, required 1", a_count, k);
        end
      end
    end
    checks++;
    if (got !== 100 || a_count !== 3'd0 || a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL stream_total: transfers=%0d count=%0d valid=%b, required 100 0 0", got, a_count, a_ovalid);
    end
    a_ivalid = 1'b0;
    a_iready = 1'b0;
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] q [$];
    logic       push, pop;
    int         exp_n;
    b_ivalid = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      // Source protocol: a pending, unaccepted word stays on the bus unchanged.
      if (!b_ivalid) begin
        b_ivalid = ($urandom_range(0, 1) == 1);
        b_idata  = 8'($urandom_range(0, 255));
      end
      b_iready = ($urandom_range(0, 2) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      #1;
      exp_n = q.size();
      checks++;
      if (b_count !== 2'(exp_n) || b_oready !== (exp_n != 3) || b_ovalid !== (exp_n != 0)) begin
        errors++;
        $display("FAIL wrap_status: count=%0d ready=%b valid=%b, required %0d %b %b",
                 b_count, b_oready, b_ovalid, exp_n, (exp_n != 3), (exp_n != 0));
      end
      if (exp_n != 0) begin
        checks++;
        if (b_odata !== q[0]) begin
          errors++;
          $display("FAIL wrap_data: got %h, required %h at cycle %0d", b_odata, q[0], k);
        end
      end
      push = b_ivalid && (exp_n != 3);
      pop  = b_iready && (exp_n != 0);
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(b_idata);
        b_ivalid = 1'b0;
      end
    end
    b_ivalid = 1'b0;
    b_iready = 1'b0;
  endtask

  task automatic test_pop_at_full();
    logic [7:0] seen [$];
    c_iready = 1'b0;
    c_ivalid = 1'b1; c_idata = 8'hA0; tick();
    c_idata = 8'hA1; tick();
    checks++;
    if (c_count !== 2'd2 || c_oready !== 1'b0) begin
      errors++;
      $display("FAIL popfull_full: count=%0d ready=%b, required 2 0", c_count, c_oready);
    end
    c_idata  = 8'hA2;
    c_iready = 1'b1;
    if (c_ovalid) seen.push_back(c_odata);
    tick();
    checks++;
    if (c_count !== 2'd1 || c_oready !== 1'b1) begin
      errors++;
      $display("FAIL popfull_after: count=%0d ready=%b, required 1 1", c_count, c_oready);
    end
    if (c_ovalid) seen.push_back(c_odata);
    tick();
    c_ivalid = 1'b0;
    checks++;
    if (c_count !== 2'd1 || c_odata !== 8'hA2) begin
      errors++;
      $display("FAIL popfull_accept: count=%0d data=%h, required 1 a2", c_count, c_odata);
    end
    if (c_ovalid) seen.push_back(c_odata);
    tick();
    checks++;
    if (seen.size() != 3 || seen[0] !== 8'hA0 || seen[1] !== 8'hA1 || seen[2] !== 8'hA2 || c_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL popfull_order: got %0d words valid=%b, required a0 a1 a2 then idle", seen.size(), c_ovalid);
    end
    c_iready = 1'b0;
  endtask

`ifdef PIPE_SKID_FIFO_FLUSH_EN
  task automatic test_flush();
    a_iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_ivalid = 1'b1; a_idata = 8'(i + 1); tick();
    end
    a_flush = 1'b1; a_ivalid = 1'b1; a_idata = 8'h77; a_iready = 1'b1;
    tick();
    a_flush = 1'b0; a_ivalid = 1'b0;
    checks++;
    if (a_count !== 3'd0 || a_ovalid !== 1'b0 || a_oready !== 1'b1 || a_empty !== 1'b1 || a_afull !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: count=%0d valid=%b ready=%b empty=%b afull=%b, required 0 0 1 1 0",
               a_count, a_ovalid, a_oready, a_empty, a_afull);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (a_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_output: valid=%b data=%h, required 0", a_ovalid, a_odata);
      end
    end
    a_iready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_pointer_wrap();
    test_pop_at_full();
`ifdef PIPE_SKID_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
